// File: rtl/cp0_pkg.sv
// cp0_pkg: register numbers, exception codes and bit-field positions for the CP0 exception unit
package cp0_pkg;
  localparam logic [4:0] REG_SR = 5'd12, REG_CAUSE = 5'd13, REG_EPC = 5'd14, REG_PRID = 5'd15;
  localparam logic [4:0] EXC_INT = 5'd0, EXC_ADEL = 5'd4, EXC_ADES = 5'd5, EXC_RI = 5'd10, EXC_OV = 5'd12;
  localparam int SR_IE = 0, SR_EXL = 1, IM_LO = 10, IM_HI = 15;
  localparam int CAUSE_BD = 31, IP_LO = 10, IP_HI = 15, EXC_LO = 2, EXC_HI = 6;
  typedef enum logic {RUN, HANDLER} mode_e;
endpackage

// File: rtl/cp0_exc_arbiter.sv
// cp0_exc_arbiter: decides whether to take an interrupt or exception this cycle and the ExcCode to record
module cp0_exc_arbiter
  import cp0_pkg::*;
(
  input  logic       en,
  input  logic [5:0] ip,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [4:0] exc_code,
  output logic       int_req,
  output logic       exc_req,
  output logic       take,
  output logic [4:0] exc_next
);
  assign int_req  = en & (|(ip & im)) & ie & ~exl;
  assign exc_req  = en & (|exc_code) & ~exl;
  assign take     = int_req | exc_req;
  assign exc_next = int_req ? EXC_INT : exc_code;
endmodule

// File: rtl/cp0_exception_unit.sv
// cp0_exception_unit: CP0 SR/Cause/EPC/PRId registers, EXL mode FSM and fetch redirect
module cp0_exception_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID         = 32'h4D49_5053
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        eret_m,
  output logic [31:0] cp0_rdata,
  output logic        GOTO_HANDLER,
  output logic        ERET,
  output logic [31:0] EPC,
  output logic [31:0] handler_pc
);
  mode_e       mode_q, mode_d;
  logic [5:0]  im_q, ip_q;
  logic        ie_q, bd_q;
  logic [4:0]  exc_q, exc_next;
  logic [31:0] epc_q, sr_val, cause_val;
  logic        int_req, exc_req, take, exl, wr;
  assign exl = mode_q == HANDLER;
  assign wr  = cp0_we & ~take;
  cp0_exc_arbiter u_arb (
    .en(reset), .ip(ip_q), .im(im_q), .ie(ie_q), .exl(exl), .exc_code(exc_code_m),
    .int_req(int_req), .exc_req(exc_req), .take(take), .exc_next(exc_next)
  );
  assign GOTO_HANDLER = take;
  assign ERET         = reset & eret_m & ~take;
  assign EPC          = epc_q;
  assign handler_pc   = HANDLER_ADDR;
  // EXL: taking wins over return, return wins over a software write of SR.EXL
  always_comb
    mode_d = take ? HANDLER :
             ERET ? RUN :
             (wr && cp0_addr == REG_SR) ? (cp0_wdata[SR_EXL] ? HANDLER : RUN) : mode_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) mode_q <= RUN;
    else mode_q <= mode_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      im_q  <= '0;
      ie_q  <= 1'b0;
      ip_q  <= '0;
      bd_q  <= 1'b0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      ip_q <= hw_int;
      if (take) begin
        bd_q  <= bd_m;
        exc_q <= exc_next;
        epc_q <= bd_m ? pc_m - 32'd4 : pc_m;
      end else if (wr) begin
        if (cp0_addr == REG_SR) begin
          im_q <= cp0_wdata[IM_HI:IM_LO];
          ie_q <= cp0_wdata[SR_IE];
        end
        if (cp0_addr == REG_EPC) epc_q <= cp0_wdata;
      end
    end
  assign sr_val    = {16'h0, im_q, 8'h0, exl, ie_q};
  assign cause_val = {bd_q, 15'h0, ip_q, 3'h0, exc_q, 2'h0};
  always_comb
    cp0_rdata = (cp0_addr == REG_SR)    ? sr_val :
                (cp0_addr == REG_CAUSE) ? cause_val :
                (cp0_addr == REG_EPC)   ? epc_q :
                (cp0_addr == REG_PRID)  ? PRID : 32'h0;
endmodule
